// File: rtl/player_anim_ctrl.sv
// ---------------------------------------------------------------------------
// player_anim_ctrl
//
// Purpose:
//   Animation sequencer and ROM address generator for the player sprite.
//   The sprite ROM holds 16 frames of SPR_W x SPR_H pixels. Once per video
//   frame the key inputs choose a facing direction and a pose. For every VGA
//   draw pixel the block produces the ROM read address of the matching
//   sprite pixel. It also flags the pixels that fall inside the sprite, with
//   the flag aligned to the ROM's registered output.
//
// Ports:
//   Clk        in   1       system clock
//   Reset_n    in   1       asynchronous active-low reset
//   frame_clk  in   1       vsync-rate level; each rising edge is one frame tick
//   key_up     in   1       move up request (W), level
//   key_down   in   1       move down request (S), level
//   key_left   in   1       move left request (A), level
//   key_right  in   1       move right request (D), level
//   key_attack in   1       attack request, level
//   DrawX      in   10      current VGA pixel column
//   DrawY      in   10      current VGA pixel row
//   PlayerX    in   10      sprite top-left column on screen
//   PlayerY    in   10      sprite top-left row on screen
//   rom_addr   out  ADDR_W  sprite ROM read address (1 Clk after DrawX/DrawY)
//   pixel_hit  out  1       ROM data_Out in this cycle belongs to the sprite
//   frame_idx  out  4       current frame = dir*4 + pose
//   attacking  out  1       high while the attack pose is held
// ---------------------------------------------------------------------------
module player_anim_ctrl #(
    parameter int SPR_W         = 18,
    parameter int SPR_H         = 20,
    parameter int WALK_DIV      = 8,
    parameter int ATTACK_FRAMES = 12,
    parameter int ADDR_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              key_up,
    input  logic              key_down,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_attack,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pixel_hit,
    output logic [3:0]        frame_idx,
    output logic              attacking
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_ATTACK = 2'd2
    } state_t;

    // Direction codes double as the upper two bits of the frame index.
    localparam logic [1:0] DIR_FRONT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_BACK  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] POSE_IDLE   = 2'd2;
    localparam logic [1:0] POSE_ATTACK = 2'd3;

    localparam int WCNT_W = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam int ACNT_W = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES + 1) : 1;

    localparam logic [WCNT_W-1:0] WALK_LAST  = WCNT_W'(WALK_DIV - 1);
    localparam logic [ACNT_W-1:0] ATK_LOAD   = ACNT_W'(ATTACK_FRAMES);
    localparam logic [ACNT_W-1:0] ATK_LAST   = ACNT_W'(1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);

    state_t            state, next_state;
    logic [1:0]        dir, next_dir;
    logic [WCNT_W-1:0] walk_cnt, next_walk_cnt;
    logic              step, next_step;
    logic [ACNT_W-1:0] atk_cnt, next_atk_cnt;
    logic [1:0]        next_pose;

    logic fclk_s1, fclk_s2, fclk_prev;
    logic tick;

    logic       any_move;
    logic [1:0] move_dir;

    logic signed [10:0] rel_x, rel_y;
    logic               in_win;
    logic [ADDR_W-1:0]  offset, base;
    logic               hit_d1;

    // frame_clk comes from the video timing domain, so it is synchronised
    // through two flops; a third flop remembers the previous level so a
    // held-high frame_clk yields exactly one tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fclk_s1   <= 1'b0;
            fclk_s2   <= 1'b0;
            fclk_prev <= 1'b0;
        end else begin
            fclk_s1   <= frame_clk;
            fclk_s2   <= fclk_s1;
            fclk_prev <= fclk_s2;
        end
    end

    assign tick = fclk_s2 & ~fclk_prev;

    // Movement key decode with fixed priority up > down > left > right,
    // which also settles opposing key pairs.
    always_comb begin
        any_move = key_up | key_down | key_left | key_right;
        move_dir = DIR_RIGHT;
        if (key_up) begin
            move_dir = DIR_BACK;
        end else if (key_down) begin
            move_dir = DIR_FRONT;
        end else if (key_left) begin
            move_dir = DIR_LEFT;
        end
    end

    // Next-state logic. Everything holds between ticks; on a tick the FSM
    // reacts to the sampled keys. Attack always wins over movement, and
    // while attacking the keys are ignored until the countdown expires.
    always_comb begin
        next_state    = state;
        next_dir      = dir;
        next_walk_cnt = walk_cnt;
        next_step     = step;
        next_atk_cnt  = atk_cnt;

        if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (key_attack) begin
                        next_state   = ST_ATTACK;
                        next_atk_cnt = ATK_LOAD;
                    end else if (any_move) begin
                        next_state    = ST_WALK;
                        next_dir      = move_dir;
                        next_walk_cnt = '0;
                        next_step     = 1'b0;
                    end
                end
                ST_WALK: begin
                    if (key_attack) begin
                        next_state   = ST_ATTACK;
                        next_atk_cnt = ATK_LOAD;
                    end else if (!any_move) begin
                        next_state = ST_IDLE;
                    end else begin
                        // Turning keeps the walk cadence running.
                        next_dir = move_dir;
                        if (walk_cnt == WALK_LAST) begin
                            next_walk_cnt = '0;
                            next_step     = ~step;
                        end else begin
                            next_walk_cnt = walk_cnt + 1'b1;
                        end
                    end
                end
                ST_ATTACK: begin
                    next_atk_cnt = atk_cnt - 1'b1;
                    if (atk_cnt == ATK_LAST) begin
                        next_state = ST_IDLE;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end

        unique case (next_state)
            ST_WALK:   next_pose = {1'b0, next_step};
            ST_ATTACK: next_pose = POSE_ATTACK;
            default:   next_pose = POSE_IDLE;
        endcase
    end

    // State registers. frame_idx and attacking are built from the next
    // values so they update in the cycle right after the tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            dir       <= DIR_FRONT;
            walk_cnt  <= '0;
            step      <= 1'b0;
            atk_cnt   <= '0;
            frame_idx <= {DIR_FRONT, POSE_IDLE};
            attacking <= 1'b0;
        end else begin
            state     <= next_state;
            dir       <= next_dir;
            walk_cnt  <= next_walk_cnt;
            step      <= next_step;
            atk_cnt   <= next_atk_cnt;
            frame_idx <= {next_dir, next_pose};
            attacking <= (next_state == ST_ATTACK);
        end
    end

    // Sprite-relative position. Zero-extending to 11 bits and subtracting
    // gives a proper signed difference, so pixels left of or above the
    // sprite come out negative instead of wrapping into the window.
    always_comb begin
        rel_x  = $signed({1'b0, DrawX}) - $signed({1'b0, PlayerX});
        rel_y  = $signed({1'b0, DrawY}) - $signed({1'b0, PlayerY});
        in_win = !rel_x[10] && (rel_x[9:0] < 10'(SPR_W)) &&
                 !rel_y[10] && (rel_y[9:0] < 10'(SPR_H));
        offset = ADDR_W'(rel_y[9:0]) * ADDR_W'(SPR_W) + ADDR_W'(rel_x[9:0]);
        base   = ADDR_W'(frame_idx) * FRAME_SIZE;
    end

    // Address register plus the two-stage hit pipe. The ROM adds one more
    // cycle after rom_addr, so pixel_hit lags the window test by two.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            pixel_hit <= 1'b0;
        end else begin
            rom_addr  <= in_win ? (base + offset) : '0;
            hit_d1    <= in_win;
            pixel_hit <= hit_d1;
        end
    end

endmodule

// File: tb/tb_player_anim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_anim_ctrl
//
// Purpose:
//   Self-checking bench for player_anim_ctrl. It keeps a behavioural model
//   of the animation rules and of the sprite address mapping. It drives
//   directed and random key and pixel sequences, then compares the DUT
//   outputs with the model.
// ---------------------------------------------------------------------------
module tb_player_anim_ctrl;

    localparam int SPR_W         = 18;
    localparam int SPR_H         = 20;
    localparam int WALK_DIV      = 8;
    localparam int ATTACK_FRAMES = 12;
    localparam int ADDR_W        = 16;

    logic              Clk;
    logic              Reset_n;
    logic              frame_clk;
    logic              key_up, key_down, key_left, key_right, key_attack;
    logic [9:0]        DrawX, DrawY, PlayerX, PlayerY;
    logic [ADDR_W-1:0] rom_addr;
    logic              pixel_hit;
    logic [3:0]        frame_idx;
    logic              attacking;

    int checks;
    int failures;

    // Model state: mode 0 = idle, 1 = walk, 2 = attack.
    int m_mode;
    int m_dir;
    int m_walk_ticks;
    int m_atk_ticks;

    // Pixel pipeline expectations.
    int exp_addr_d1;
    int exp_hit_d1;
    int exp_hit_d2;
    int pipe_fill;

    player_anim_ctrl #(
        .SPR_W        (SPR_W),
        .SPR_H        (SPR_H),
        .WALK_DIV     (WALK_DIV),
        .ATTACK_FRAMES(ATTACK_FRAMES),
        .ADDR_W       (ADDR_W)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_attack(key_attack),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .PlayerX   (PlayerX),
        .PlayerY   (PlayerY),
        .rom_addr  (rom_addr),
        .pixel_hit (pixel_hit),
        .frame_idx (frame_idx),
        .attacking (attacking)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One comparison: counted, asserted, reported on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pickDir(input logic u, input logic d, input logic l);
        if (u) return 2;
        if (d) return 0;
        if (l) return 1;
        return 3;
    endfunction

    function automatic int modelFrame();
        int pose;
        if (m_mode == 1)      pose = (m_walk_ticks / WALK_DIV) % 2;
        else if (m_mode == 2) pose = 3;
        else                  pose = 2;
        return m_dir * 4 + pose;
    endfunction

    task automatic modelReset();
        m_mode       = 0;
        m_dir        = 0;
        m_walk_ticks = 0;
        m_atk_ticks  = 0;
    endtask

    task automatic modelTick(input logic u, input logic d, input logic l, input logic r, input logic a);
        logic any;
        any = u | d | l | r;
        if (m_mode == 2) begin
            m_atk_ticks++;
            if (m_atk_ticks == ATTACK_FRAMES) m_mode = 0;
        end else if (a) begin
            m_mode      = 2;
            m_atk_ticks = 0;
        end else if (m_mode == 0) begin
            if (any) begin
                m_mode       = 1;
                m_dir        = pickDir(u, d, l);
                m_walk_ticks = 0;
            end
        end else begin
            if (!any) begin
                m_mode = 0;
            end else begin
                m_dir = pickDir(u, d, l);
                m_walk_ticks++;
            end
        end
    endtask

    function automatic int pixelIn(input int x, input int y, input int px, input int py);
        int rx, ry;
        rx = x - px;
        ry = y - py;
        return (rx >= 0 && rx < SPR_W && ry >= 0 && ry < SPR_H) ? 1 : 0;
    endfunction

    function automatic int pixelAddr(input int x, input int y, input int px, input int py);
        if (pixelIn(x, y, px, py) == 0) return 0;
        return modelFrame() * SPR_W * SPR_H + (y - py) * SPR_W + (x - px);
    endfunction

    task automatic setKeys(input logic u, input logic d, input logic l, input logic r, input logic a);
        key_up     = u;
        key_down   = d;
        key_left   = l;
        key_right  = r;
        key_attack = a;
    endtask

    // One frame tick with the given keys held, mirrored into the model.
    task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r, input logic a);
        @(posedge Clk);
        #1;
        setKeys(u, d, l, r, a);
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        modelTick(u, d, l, r, a);
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_frame"}, 32'(frame_idx), 32'(modelFrame()));
        checkOutput({tag, "_atk"}, 32'(attacking), 32'(m_mode == 2));
    endtask

    // Streams one pixel per clock and checks the pipelined outputs of the
    // pixels driven one and two cycles earlier.
    task automatic pixelStep(input int x, input int y);
        @(posedge Clk);
        #1;
        if (pipe_fill >= 1) checkOutput("pix_addr", 32'(rom_addr), 32'(exp_addr_d1));
        if (pipe_fill >= 2) checkOutput("pix_hit", 32'(pixel_hit), 32'(exp_hit_d2));
        exp_hit_d2  = exp_hit_d1;
        exp_hit_d1  = pixelIn(x, y, int'(PlayerX), int'(PlayerY));
        exp_addr_d1 = pixelAddr(x, y, int'(PlayerX), int'(PlayerY));
        if (pipe_fill < 2) pipe_fill++;
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    task automatic randomPixels(input int n);
        int x, y;
        pipe_fill = 0;
        PlayerX   = 10'($urandom_range(0, 990));
        PlayerY   = 10'($urandom_range(0, 990));
        for (int i = 0; i < n; i++) begin
            x = (int'(PlayerX) + $urandom_range(0, SPR_W + 5) - 3) & 10'h3ff;
            y = (int'(PlayerY) + $urandom_range(0, SPR_H + 5) - 3) & 10'h3ff;
            pixelStep(x, y);
        end
        pixelStep(x, y);
        pixelStep(x, y);
    endtask

    task automatic doReset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int exp12;
        checks    = 0;
        failures  = 0;
        pipe_fill = 0;
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        setKeys(0, 0, 0, 0, 0);
        PlayerX = 10'd100;
        PlayerY = 10'd50;
        DrawX   = 10'd105;
        DrawY   = 10'd55;
        modelReset();

        // Reset state, with a pixel inside the sprite window on the inputs.
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_frame", 32'(frame_idx), 32'd2);
        checkOutput("rst_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst_hit", 32'(pixel_hit), 32'd0);
        checkOutput("rst_atk", 32'(attacking), 32'd0);
        Reset_n = 1'b1;
        DrawX   = 10'd0;
        DrawY   = 10'd0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle_frame", 32'(frame_idx), 32'd2);

        // Walk right for 17 ticks: step changes every WALK_DIV ticks.
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            exp12 = (i <= 8 || i == 17) ? 12 : 13;
            checkOutput($sformatf("walk_r%0d", i), 32'(frame_idx), 32'(exp12));
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("release_r", 32'(frame_idx), 32'd14);

        // Attack while walking right, then the pose is held for 12 ticks.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("atk_enter_frame", 32'(frame_idx), 32'd15);
        checkOutput("atk_enter_flag", 32'(attacking), 32'd1);
        for (int i = 2; i <= ATTACK_FRAMES; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput($sformatf("atk_hold%0d", i), 32'(attacking), 32'd1);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("atk_exit_frame", 32'(frame_idx), 32'd14);
        checkOutput("atk_exit_flag", 32'(attacking), 32'd0);

        // Address mapping in the idle-front frame, including window edges.
        setKeys(0, 0, 0, 0, 0);
        doReset();
        PlayerX = 10'd100;
        PlayerY = 10'd50;
        @(posedge Clk);
        #1;
        DrawX = 10'd117;
        DrawY = 10'd69;
        @(posedge Clk);
        #1;
        checkOutput("addr_1079", 32'(rom_addr), 32'd1079);
        DrawX = 10'd118;
        @(posedge Clk);
        #1;
        checkOutput("hit_1079", 32'(pixel_hit), 32'd1);
        checkOutput("addr_x118", 32'(rom_addr), 32'd0);
        DrawX = 10'd99;
        @(posedge Clk);
        #1;
        checkOutput("hit_x118", 32'(pixel_hit), 32'd0);
        checkOutput("addr_x99", 32'(rom_addr), 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("hit_x99", 32'(pixel_hit), 32'd0);
        pipe_fill = 0;
        pixelStep(100, 50);
        pixelStep(117, 50);
        pixelStep(100, 69);
        pixelStep(100, 70);
        pixelStep(100, 49);
        pixelStep(117, 69);
        pixelStep(117, 69);
        pixelStep(117, 69);

        // Near-zero sprite origin: DrawX far to the right must not wrap in.
        PlayerX   = 10'd0;
        PlayerY   = 10'd0;
        pipe_fill = 0;
        pixelStep(1021, 5);
        pixelStep(0, 0);
        pixelStep(17, 19);
        pixelStep(17, 1023);
        pixelStep(17, 1023);
        pixelStep(17, 1023);

        // Up+right resolves to back; up+down also resolves to back.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 1, 0);
            checkFrame($sformatf("up_right%0d", i));
        end
        checkOutput("up_right_dir", 32'(frame_idx[3:2]), 32'd2);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("up_down_dir", 32'(frame_idx[3:2]), 32'd2);
        checkFrame("up_down");

        // Random key sequences interleaved with random pixel scans.
        for (int round = 0; round < 6; round++) begin
            for (int t = 0; t < 12; t++) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 9) == 0));
                checkFrame($sformatf("rnd%0d_%0d", round, t));
            end
            randomPixels(40);
        end

        // Reset in the middle of an attack: nothing of the attack survives.
        setKeys(0, 0, 0, 0, 0);
        doReset();
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
        checkFrame("pre_rst_atk");
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_frame", 32'(frame_idx), 32'd2);
        checkOutput("mid_rst_atk", 32'(attacking), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_rst_frame", 32'(frame_idx), 32'd2);
        checkOutput("post_rst_atk", 32'(attacking), 32'd0);

        // A held-high frame_clk yields exactly one tick.
        @(posedge Clk);
        #1;
        setKeys(0, 0, 0, 1, 0);
        frame_clk = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        modelTick(0, 0, 0, 1, 0);
        checkOutput("held_fclk_first", 32'(frame_idx), 32'd12);
        setKeys(0, 0, 1, 0, 0);
        repeat (20) @(posedge Clk);
        #1;
        checkOutput("held_fclk_no_retick", 32'(frame_idx), 32'd12);
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        applyStimulus(0, 0, 1, 0, 0);
        checkFrame("after_held_fclk");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
